sca_stim_ctrl: RTL and testbench
================================

// Module: sca_stim_ctrl
// PURPOSE
//  Parametrised side-channel stimulus controller for the SAKURA-G main FPGA. Receives framed
//  commands over a 2-wire serial link (sca_clk/sca_data from FTDI), holds a base input vector
//  and a list of up to NUM_FLIPS flip indices, and on ARM drives the DUT with base then
//  base-with-flips on a divided flip_clk, pulsing trig for scope capture and latching outputs.
// PARAMETERS
//  NUM_INS     64    DUT input width (1..65535)
//  NUM_OUTS    32    DUT output width
//  IDX_W       16    bits per flip index
//  NUM_FLIPS   4     flip index slots
//  DIV         16    flip_clk half-period in M_CLK_OSC cycles (>=2)
//  SETTLE      2     flip_clk rising edges between flip apply and output capture (>=1)
//  IDLE_TO     1024  M_CLK_OSC cycles without sca_clk edge that abort a partial frame
// PORTS
//  M_CLK_OSC   in   1         system clock; all logic on its rising edge
//  reset       in   1         asynchronous, active-low
//  sca_clk     in   1         serial clock (async; 2-FF synchronised)
//  sca_data    in   1         serial data (async; 2-FF synchronised)
//  dut_inputs  out  NUM_INS   registered DUT stimulus
//  dut_outputs in   NUM_OUTS  DUT response
//  flip_clk    out  1         free-running divided clock, period 2*DIV
//  trig        out  1         scope trigger
//  busy        out  1         sequence in progress
//  frame_err   out  1         sticky protocol error
// BEHAVIOUR
//  - Reset: dut_inputs=0, flip_clk=0, trig=0, busy=0, frame_err=0, base=0, capture reg=0,
//    all flip slots = all-ones (disabled), receiver bit counter=0, FSM=IDLE.
//  - Receiver: bit sampled on synchronised sca_clk falling edge, MSB first. Frame = 8-bit
//    opcode + payload; frame length fixed by opcode. Partial frame discarded on IDLE_TO.
//    0x01 LOAD_BASE: NUM_INS bits -> base. 0x02 LOAD_FLIP: NUM_FLIPS*IDX_W bits, slot 0 first.
//    0x03 ARM (no payload). 0x04 ABORT (no payload; also clears frame_err).
//    Unknown opcode: frame_err=1, remaining bits ignored until IDLE_TO.
//    Registers update only on the cycle the final payload bit is sampled.
//  - flip_clk toggles every DIV cycles after reset, never gated.
//  - Flip mask = XOR of one-hot(slot) over slots; index >= NUM_INS (incl. all-ones) ignored;
//    duplicate indices cancel.
//  - FSM (transitions on cycle flip_clk goes 0->1, "edge"):
//    IDLE    : ARM frame -> ARMED, busy=1 next cycle.
//    ARMED   : edge -> dut_inputs<=base, -> APPLY.
//    APPLY   : edge -> dut_inputs<=base^mask, trig=1 for exactly 2*DIV cycles, -> SETTLE.
//    SETTLE  : after SETTLE edges, capture<=dut_outputs, -> IDLE, busy=0 same cycle.
//  - While busy: LOAD_BASE/LOAD_FLIP/ARM completed -> discarded, frame_err=1.
//    ABORT any state -> IDLE, trig=0, busy=0, dut_inputs<=base next cycle.
//  - Mid-sequence reset: all outputs return to reset values immediately.
// CONFIGURATION
//  SCA_READBACK_EN defined: adds port sca_rdata out 1 (reset 0) and opcode 0x05 READ; after
//  the opcode, capture reg shifts out MSB first, sca_rdata updated one cycle after each
//  synchronised sca_clk falling edge, NUM_OUTS bits then 0. READ while busy -> frame_err.
//  Not defined: no sca_rdata port, capture reg kept only for debug, 0x05 -> frame_err=1.
// TESTING
//  Reset mid-APPLY -> dut_inputs=0, trig=0, busy=0 within 1 cycle; flip slots all-ones.
//  NUM_INS=64: LOAD_BASE 0x00FF..00FF, LOAD_FLIP {3,3,63,0xFFFF}, ARM -> inputs base, then
//    base^(1<<63) (idx 3 cancels); trig high 32 cycles (DIV=16).
//  LOAD_FLIP sent while busy -> flip slots unchanged, frame_err=1; ABORT -> frame_err=0, IDLE.
//  Opcode 0x07 then IDLE_TO gap then valid ARM -> frame_err=1, sequence still runs.
//  Half frame then 1024-cycle gap then full LOAD_BASE 0xA5.. -> base equals full frame only.
//  SCA_READBACK_EN: DUT = inverter, base 0 no flips, ARM, READ -> sca_rdata streams NUM_OUTS ones.

Source files
------------

// File: rtl/sca_stim_ctrl.sv
// sca_stim_ctrl: serial-commanded base/flip stimulus sequencer for SCA capture.
// Optional SCA_READBACK_EN adds the sca_rdata port and the READ opcode.
module sca_stim_ctrl #(
   parameter int NUM_INS   = 64,
   parameter int NUM_OUTS  = 32,
   parameter int IDX_W     = 16,
   parameter int NUM_FLIPS = 4,
   parameter int DIV       = 16,
   parameter int SETTLE    = 2,
   parameter int IDLE_TO   = 1024
) (
   input  logic                M_CLK_OSC,
   input  logic                reset,
   input  logic                sca_clk,
   input  logic                sca_data,
   output logic [NUM_INS-1:0]  dut_inputs,
   input  logic [NUM_OUTS-1:0] dut_outputs,
   output logic                flip_clk,
   output logic                trig,
   output logic                busy,
   output logic                frame_err
`ifdef SCA_READBACK_EN
   ,
   output logic                sca_rdata
`endif
);
   localparam int FW    = NUM_FLIPS * IDX_W;
   localparam int PW    = (NUM_INS > FW) ? NUM_INS : FW;
   localparam int SH_W  = (PW > 8) ? PW : 8;
   localparam int CNT_W = $clog2(SH_W + 9);
   localparam int TO_W  = $clog2(IDLE_TO + 1);
   localparam int DW    = $clog2(DIV);
   localparam int SC_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   localparam logic [CNT_W-1:0] LAST_OP   = CNT_W'(7);
   localparam logic [CNT_W-1:0] LAST_BASE = CNT_W'(NUM_INS + 7);
   localparam logic [CNT_W-1:0] LAST_FLIP = CNT_W'(FW + 7);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(IDLE_TO - 1);
   localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(IDLE_TO);
   localparam logic [DW-1:0]    DIV_LAST  = DW'(DIV - 1);
   localparam logic [SC_W-1:0]  SC_LAST   = SC_W'(SETTLE - 1);
   localparam logic [NUM_INS-1:0] ONE     = NUM_INS'(1);

   localparam logic [7:0] OP_BASE  = 8'h01;
   localparam logic [7:0] OP_FLIP  = 8'h02;
   localparam logic [7:0] OP_ARM   = 8'h03;
   localparam logic [7:0] OP_ABORT = 8'h04;
   localparam logic [7:0] OP_READ  = 8'h05;

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_APPLY, S_SETTLE} state_t;

   logic [2:0]          clk_s;
   logic [1:0]          dat_s;
   logic [TO_W-1:0]     to_cnt;
   logic                fall, any_edge, timeout;
   logic [SH_W-2:0]     shreg;
   logic [SH_W-1:0]     sh_nxt;
   logic [CNT_W-1:0]    bit_cnt;
   logic [7:0]          op, op_nxt;
   logic                ignore, take, op_done, op_ok, has_pay;
   logic                ev_base, ev_flip, ev_arm, ev_abort, ev_read, ev_bad;
   logic                rd_on;
   logic [NUM_INS-1:0]  base, mask;
   logic [IDX_W-1:0]    flips [NUM_FLIPS];
   logic [NUM_OUTS-1:0] capture;
   logic [DW-1:0]       div_cnt;
   logic                flip_rise;
   logic [SC_W-1:0]     scnt;
   state_t              state;

   assign fall      = clk_s[2] & ~clk_s[1];
   assign any_edge  = clk_s[2] ^ clk_s[1];
   assign timeout   = !any_edge && (to_cnt == TO_LAST);
   assign flip_rise = !flip_clk && (div_cnt == DIV_LAST);

   always_ff @(posedge M_CLK_OSC or negedge reset) begin
      if (!reset) begin
         clk_s  <= '0;
         dat_s  <= '0;
         to_cnt <= '0;
      end else begin
         clk_s <= {clk_s[1:0], sca_clk};
         dat_s <= {dat_s[0], sca_data};
         if (any_edge)
            to_cnt <= '0;
         else if (to_cnt != TO_MAX)
            to_cnt <= to_cnt + 1'b1;
      end
   end

   always_comb begin
      sh_nxt   = {shreg, dat_s[1]};
      op_nxt   = sh_nxt[7:0];
      take     = fall && !ignore && !rd_on;
      op_done  = take && (bit_cnt == LAST_OP);
      ev_base  = take && (op == OP_BASE) && (bit_cnt == LAST_BASE);
      ev_flip  = take && (op == OP_FLIP) && (bit_cnt == LAST_FLIP);
      ev_arm   = op_done && (op_nxt == OP_ARM);
      ev_abort = op_done && (op_nxt == OP_ABORT);
      has_pay  = (op_nxt == OP_BASE) || (op_nxt == OP_FLIP);
      op_ok    = has_pay || (op_nxt == OP_ARM) || (op_nxt == OP_ABORT);
      ev_read  = 1'b0;
`ifdef SCA_READBACK_EN
      ev_read  = op_done && (op_nxt == OP_READ);
      op_ok    = op_ok || (op_nxt == OP_READ);
`endif
      ev_bad   = op_done && !op_ok;
   end

   // Unknown opcode: swallow the rest of the frame until the link goes idle
   always_ff @(posedge M_CLK_OSC or negedge reset) begin
      if (!reset) begin
         shreg   <= '0;
         bit_cnt <= '0;
         op      <= '0;
         ignore  <= 1'b0;
      end else if (timeout) begin
         bit_cnt <= '0;
         ignore  <= 1'b0;
      end else if (take) begin
         shreg <= sh_nxt[SH_W-2:0];
         if (op_done) begin
            if (has_pay) begin
               op      <= op_nxt;
               bit_cnt <= bit_cnt + 1'b1;
            end else begin
               bit_cnt <= '0;
               ignore  <= ev_bad;
            end
         end else if (ev_base || ev_flip) begin
            bit_cnt <= '0;
         end else begin
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      mask = '0;
      for (int s = 0; s < NUM_FLIPS; s++)
         if (32'(flips[s]) < NUM_INS)
            mask = mask ^ (ONE << flips[s]);
   end

   always_ff @(posedge M_CLK_OSC or negedge reset) begin
      if (!reset) begin
         div_cnt    <= '0;
         flip_clk   <= 1'b0;
         frame_err  <= 1'b0;
         base       <= '0;
         capture    <= '0;
         dut_inputs <= '0;
         trig       <= 1'b0;
         busy       <= 1'b0;
         scnt       <= '0;
         state      <= S_IDLE;
         for (int s = 0; s < NUM_FLIPS; s++)
            flips[s] <= '1;
      end else begin
         if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            flip_clk <= ~flip_clk;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
         if (ev_abort)
            frame_err <= 1'b0;
         else if (ev_bad || (busy && (ev_base || ev_flip || ev_arm || ev_read)))
            frame_err <= 1'b1;
         if (!busy && ev_base)
            base <= sh_nxt[NUM_INS-1:0];
         if (!busy && ev_flip)
            for (int s = 0; s < NUM_FLIPS; s++)
               flips[s] <= sh_nxt[FW-1-s*IDX_W -: IDX_W];
         if (ev_abort) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            trig       <= 1'b0;
            dut_inputs <= base;
         end else begin
            unique case (state)
               S_IDLE: if (ev_arm) begin
                  state <= S_ARMED;
                  busy  <= 1'b1;
               end
               S_ARMED: if (flip_rise) begin
                  dut_inputs <= base;
                  state      <= S_APPLY;
               end
               S_APPLY: if (flip_rise) begin
                  dut_inputs <= base ^ mask;
                  trig       <= 1'b1;
                  scnt       <= '0;
                  state      <= S_SETTLE;
               end
               S_SETTLE: if (flip_rise) begin
                  trig <= 1'b0;
                  if (scnt == SC_LAST) begin
                     capture <= dut_outputs;
                     busy    <= 1'b0;
                     state   <= S_IDLE;
                  end else begin
                     scnt <= scnt + 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

`ifdef SCA_READBACK_EN
   localparam int RC_W = $clog2(NUM_OUTS + 1);
   logic [RC_W-1:0]     rd_cnt;
   logic [NUM_OUTS-1:0] rd_sh;

   // While streaming, sca_clk falls clock data out instead of into the receiver
   always_ff @(posedge M_CLK_OSC or negedge reset) begin
      if (!reset) begin
         rd_on     <= 1'b0;
         rd_cnt    <= '0;
         rd_sh     <= '0;
         sca_rdata <= 1'b0;
      end else if (timeout) begin
         rd_on  <= 1'b0;
         rd_cnt <= '0;
      end else if (ev_read && !busy) begin
         rd_on  <= 1'b1;
         rd_cnt <= RC_W'(NUM_OUTS);
         rd_sh  <= capture;
      end else if (fall) begin
         if (rd_on) begin
            sca_rdata <= rd_sh[NUM_OUTS-1];
            rd_sh     <= rd_sh << 1;
            rd_cnt    <= rd_cnt - 1'b1;
            rd_on     <= (rd_cnt != RC_W'(1));
         end else begin
            sca_rdata <= 1'b0;
         end
      end
   end
`else
   logic unused_capture;
   assign rd_on          = 1'b0;
   assign unused_capture = ^capture;
`endif

endmodule

// File: tb/tb_sca_stim_ctrl.sv
// tb_sca_stim_ctrl: scoreboard bench for sca_stim_ctrl.
// Expected stimulus words are queued at ARM and popped at each sequence step.
module tb_sca_stim_ctrl;
   localparam int NI = 64;
   localparam int NO = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          sca_clk;
   logic          sca_data;
   logic [NI-1:0] dut_inputs;
   logic [NO-1:0] dut_outputs;
   logic          flip_clk, trig, busy, frame_err;
`ifdef SCA_READBACK_EN
   logic          sca_rdata;
`endif

   int tests = 0;
   int fails = 0;

   logic [NI-1:0] exp_q[$];
   logic [NI-1:0] base_m;
   logic [15:0]   slot_m [4];

   always #5 clk = ~clk;

   assign dut_outputs = ~dut_inputs[NO-1:0];

   sca_stim_ctrl #(
      .NUM_INS(NI), .NUM_OUTS(NO), .IDX_W(16), .NUM_FLIPS(4),
      .DIV(16), .SETTLE(16), .IDLE_TO(1024)
   ) dut (
      .M_CLK_OSC(clk),
      .reset(reset),
      .sca_clk(sca_clk),
      .sca_data(sca_data),
      .dut_inputs(dut_inputs),
      .dut_outputs(dut_outputs),
      .flip_clk(flip_clk),
      .trig(trig),
      .busy(busy),
`ifdef SCA_READBACK_EN
      .sca_rdata(sca_rdata),
`endif
      .frame_err(frame_err)
   );

   function automatic logic [NI-1:0] mask_m();
      logic [NI-1:0] m;
      m = '0;
      for (int s = 0; s < 4; s++)
         if (slot_m[s] < NI)
            m[slot_m[s]] = ~m[slot_m[s]];
      return m;
   endfunction

   task automatic send_bits(input logic [NI-1:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         sca_data = v[i];
         sca_clk  = 1'b1;
         repeat (3) @(negedge clk);
         sca_clk  = 1'b0;
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic send_op(input logic [7:0] op);
      send_bits({56'b0, op}, 8);
   endtask

   task automatic send_arm(input bit push);
      if (push) begin
         exp_q.push_back(base_m);
         exp_q.push_back(base_m ^ mask_m());
      end
      send_op(8'h03);
   endtask

   task automatic run_monitor(input string nm);
      int n;
      logic [NI-1:0] e;
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL %s busy_set: got %b want 1", nm, busy);
         return;
      end
      n = 0;
      while (flip_clk !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      while (flip_clk !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      tests++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      if (n >= 100 || dut_inputs !== e) begin
         fails++;
         $display("FAIL %s base_stage: got %h want %h", nm, dut_inputs, e);
      end
      n = 0;
      while (trig !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      tests++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      if (n >= 100 || dut_inputs !== e) begin
         fails++;
         $display("FAIL %s flip_stage: got %h want %h", nm, dut_inputs, e);
      end
      n = 0;
      while (trig === 1'b1 && n < 200) begin n++; @(negedge clk); end
      tests++;
      if (n !== 32) begin
         fails++;
         $display("FAIL %s trig_len: got %0d want 32", nm, n);
      end
      n = 0;
      while (busy !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL %s busy_clear: got %b want 0", nm, busy);
      end
   endtask

   task automatic test_reset();
      int c;
      reset    = 1'b0;
      sca_clk  = 1'b0;
      sca_data = 1'b0;
      base_m   = '0;
      for (int s = 0; s < 4; s++) slot_m[s] = 16'hFFFF;
      repeat (3) @(negedge clk);
      tests += 5;
      if (dut_inputs !== '0) begin fails++; $display("FAIL rst_inputs: got %h want 0", dut_inputs); end
      if (flip_clk !== 1'b0) begin fails++; $display("FAIL rst_flip_clk: got %b want 0", flip_clk); end
      if (trig !== 1'b0) begin fails++; $display("FAIL rst_trig: got %b want 0", trig); end
      if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
      if (frame_err !== 1'b0) begin fails++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
      reset = 1'b1;
      c = 0;
      while (flip_clk !== 1'b1 && c < 100) begin @(negedge clk); c++; end
      c = 0;
      while (flip_clk === 1'b1 && c < 100) begin @(negedge clk); c++; end
      while (flip_clk !== 1'b1 && c < 100) begin @(negedge clk); c++; end
      tests++;
      if (c !== 32) begin fails++; $display("FAIL flip_clk_period: got %0d want 32", c); end
   endtask

   task automatic test_sequence();
      base_m = 64'h00FF00FF00FF00FF;
      send_op(8'h01);
      send_bits(base_m, 64);
      slot_m[0] = 16'd3; slot_m[1] = 16'd3; slot_m[2] = 16'd63; slot_m[3] = 16'hFFFF;
      send_op(8'h02);
      send_bits({16'd3, 16'd3, 16'd63, 16'hFFFF}, 64);
      tests++;
      if (frame_err !== 1'b0) begin fails++; $display("FAIL seq_err: got %b want 0", frame_err); end
      tests++;
      if ((base_m ^ mask_m()) !== 64'h80FF00FF00FF00FF) begin
         fails++;
         $display("FAIL seq_model: got %h want 80ff00ff00ff00ff", base_m ^ mask_m());
      end
      send_arm(1'b1);
      run_monitor("seq");
   endtask

   task automatic test_busy_load();
      send_arm(1'b1);
      fork
         run_monitor("busy_load");
         begin
            send_op(8'h02);
            send_bits({16'd1, 16'd2, 16'd5, 16'd7}, 64);
         end
      join
      tests++;
      if (frame_err !== 1'b1) begin fails++; $display("FAIL busy_err_set: got %b want 1", frame_err); end
      send_op(8'h04);
      tests += 2;
      if (frame_err !== 1'b0) begin fails++; $display("FAIL abort_err_clr: got %b want 0", frame_err); end
      if (busy !== 1'b0) begin fails++; $display("FAIL abort_idle: got %b want 0", busy); end
      send_arm(1'b1);
      run_monitor("slots_kept");
   endtask

   task automatic test_abort_mid();
      int n;
      send_arm(1'b0);
      n = 0;
      while (trig !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      send_op(8'h04);
      tests += 3;
      if (busy !== 1'b0) begin fails++; $display("FAIL abort_mid_busy: got %b want 0", busy); end
      if (trig !== 1'b0) begin fails++; $display("FAIL abort_mid_trig: got %b want 0", trig); end
      if (dut_inputs !== base_m) begin
         fails++;
         $display("FAIL abort_mid_inputs: got %h want %h", dut_inputs, base_m);
      end
   endtask

   task automatic test_bad_opcode();
      send_op(8'h07);
      tests++;
      if (frame_err !== 1'b1) begin fails++; $display("FAIL bad_op_err: got %b want 1", frame_err); end
      repeat (1100) @(negedge clk);
      send_arm(1'b1);
      run_monitor("bad_op");
      tests++;
      if (frame_err !== 1'b1) begin fails++; $display("FAIL bad_op_sticky: got %b want 1", frame_err); end
      send_op(8'h04);
      tests++;
      if (frame_err !== 1'b0) begin fails++; $display("FAIL bad_op_clr: got %b want 0", frame_err); end
   endtask

   task automatic test_timeout();
      send_op(8'h01);
      send_bits(64'h00000000FFFFFFFF, 32);
      repeat (1100) @(negedge clk);
      base_m = 64'hA5A5A5A5A5A5A5A5;
      send_op(8'h01);
      send_bits(base_m, 64);
      tests++;
      if (frame_err !== 1'b0) begin fails++; $display("FAIL timeout_err: got %b want 0", frame_err); end
      send_arm(1'b1);
      run_monitor("timeout");
   endtask

   task automatic test_reset_mid();
      int n;
      send_arm(1'b0);
      n = 0;
      while (trig !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      #2 reset = 1'b0;
      #1;
      tests += 4;
      if (dut_inputs !== '0) begin fails++; $display("FAIL mid_rst_inputs: got %h want 0", dut_inputs); end
      if (trig !== 1'b0) begin fails++; $display("FAIL mid_rst_trig: got %b want 0", trig); end
      if (busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
      if (flip_clk !== 1'b0) begin fails++; $display("FAIL mid_rst_flip_clk: got %b want 0", flip_clk); end
      @(negedge clk);
      reset  = 1'b1;
      base_m = '0;
      for (int s = 0; s < 4; s++) slot_m[s] = 16'hFFFF;
      @(negedge clk);
      send_arm(1'b1);
      run_monitor("post_reset");
   endtask

`ifdef SCA_READBACK_EN
   task automatic test_readback();
      send_op(8'h05);
      for (int i = 0; i < NO; i++) begin
         send_bits('0, 1);
         tests++;
         if (sca_rdata !== 1'b1) begin fails++; $display("FAIL rdata_bit%0d: got %b want 1", i, sca_rdata); end
      end
      send_bits('0, 1);
      tests++;
      if (sca_rdata !== 1'b0) begin fails++; $display("FAIL rdata_tail: got %b want 0", sca_rdata); end
   endtask
`endif

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_sequence();
      test_busy_load();
      test_abort_mid();
      test_bad_opcode();
      test_timeout();
      test_reset_mid();
`ifdef SCA_READBACK_EN
      test_readback();
`endif
      tests++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
